// File: rtl/mw_add_seq.sv
// Multi-word adder: one N-bit ripple-carry chunk per cycle, LSB chunk first.
// Optional macro MW_ADD_SEQ_OVF_EN adds a registered two's-complement overflow output ovf.

module rca #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    logic [N:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < N; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[N];
    end
endmodule

module mw_add_seq #(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N*WORDS-1:0]   a,
    input  logic [N*WORDS-1:0]   b,
    input  logic                 cin,
    output logic                 busy,
    output logic                 done,
    output logic [N*WORDS-1:0]   sum,
`ifdef MW_ADD_SEQ_OVF_EN
    output logic                 ovf,
`endif
    output logic                 cout
);
    localparam int W     = N * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef MW_ADD_SEQ_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic [N-1:0]     chunk_s;
    logic             chunk_co;
    logic             last_chunk;

    rca #(.N(N)) u_rca (
        .a    (a_q[idx_q*N +: N]),
        .b    (b_q[idx_q*N +: N]),
        .cin  (carry_q),
        .sum  (chunk_s),
        .cout (chunk_co)
    );

    assign last_chunk = (idx_q == IDX_W'(WORDS - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef MW_ADD_SEQ_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q*N +: N] = chunk_s;
                carry_d             = chunk_co;
                idx_d               = idx_q + IDX_W'(1);
                if (last_chunk) begin
                    cout_d  = chunk_co;
`ifdef MW_ADD_SEQ_OVF_EN
                    // Sign bits of both operands and result plus the carry out of the MSB
                    ovf_d   = a_q[W-1] ^ b_q[W-1] ^ chunk_s[N-1] ^ chunk_co;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef MW_ADD_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef MW_ADD_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Operand latches are pure data; reset never needs to touch them
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef MW_ADD_SEQ_OVF_EN
    assign ovf  = ovf_q;
`endif
endmodule
